// File: rtl/seven_seg_decoder.sv
// Recovers the byte shown on a two-digit active-low seven-segment display.
// Optional `define SEG_DECODE_ERRCNT_EN adds a saturating illegal-pattern counter (o_err_count).
module seven_seg_decoder #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [6:0] i_seg_lo,
  input  logic [6:0] i_seg_hi,
  output logic [7:0] o_byte,
  output logic       o_valid,
  output logic       o_err,
  output logic       o_blank
`ifdef SEG_DECODE_ERRCNT_EN
  ,
  output logic [7:0] o_err_count
`endif
);

  localparam int NUM_DIGITS = 2;
  localparam logic [7:0] CNT_LAST = 8'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {WAIT, DECODE, HOLD} state_t;

  typedef struct packed {
    logic       legal;
    logic       dark;
    logic [3:0] nib;
  } dec_t;

  state_t                            state;
  logic [NUM_DIGITS-1:0][6:0]        sync1, sync2, cand;
  logic [7:0]                        cnt;
  logic                              last_ok;
  dec_t [NUM_DIGITS-1:0]             dec;
  logic [NUM_DIGITS-1:0]             dig_dark, dig_bad;
  logic [7:0]                        cand_byte;

  // Raw bus is active-low; decode on the lit (inverted) pattern.
  function automatic dec_t seg_decode(input logic [6:0] raw);
    dec_t d;
    d = '{legal: 1'b1, dark: 1'b0, nib: 4'h0};
    unique case (~raw)
      7'h7E: d.nib = 4'h0;
      7'h30: d.nib = 4'h1;
      7'h6D: d.nib = 4'h2;
      7'h79: d.nib = 4'h3;
      7'h33: d.nib = 4'h4;
      7'h5B: d.nib = 4'h5;
      7'h5F: d.nib = 4'h6;
      7'h70: d.nib = 4'h7;
      7'h7F: d.nib = 4'h8;
      7'h7B: d.nib = 4'h9;
      7'h77: d.nib = 4'hA;
      7'h1F: d.nib = 4'hB;
      7'h4E: d.nib = 4'hC;
      7'h3D: d.nib = 4'hD;
      7'h4F: d.nib = 4'hE;
      7'h47: d.nib = 4'hF;
      7'h00: begin d.legal = 1'b0; d.dark = 1'b1; end
      default: d.legal = 1'b0;
    endcase
    return d;
  endfunction

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
    assign dec[g]      = seg_decode(cand[g]);
    assign dig_dark[g] = dec[g].dark;
    assign dig_bad[g]  = !dec[g].legal && !dec[g].dark;
  end

  assign cand_byte = {dec[1].nib, dec[0].nib};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync1       <= {NUM_DIGITS{7'h7F}};
      sync2       <= {NUM_DIGITS{7'h7F}};
      cand        <= {NUM_DIGITS{7'h7F}};
      cnt         <= '0;
      state       <= WAIT;
      last_ok     <= 1'b0;
      o_byte      <= 8'h00;
      o_valid     <= 1'b0;
      o_err       <= 1'b0;
      o_blank     <= 1'b1;
`ifdef SEG_DECODE_ERRCNT_EN
      o_err_count <= 8'h00;
`endif
    end else begin
      sync1   <= {i_seg_hi, i_seg_lo};
      sync2   <= sync1;
      o_valid <= 1'b0;
      o_err   <= 1'b0;

      // Decode always uses the cand that was stable, even if the sample moves now.
      if (state == DECODE) begin
        if (|dig_dark) begin
          o_blank <= 1'b1;
          last_ok <= 1'b0;
        end else if (|dig_bad) begin
          o_blank <= 1'b0;
          o_err   <= 1'b1;
          last_ok <= 1'b0;
`ifdef SEG_DECODE_ERRCNT_EN
          if (o_err_count != 8'hFF) o_err_count <= o_err_count + 8'd1;
`endif
        end else begin
          o_blank <= 1'b0;
          last_ok <= 1'b1;
          if (cand_byte != o_byte || !last_ok) begin
            o_byte  <= cand_byte;
            o_valid <= 1'b1;
          end
        end
      end

      if (sync2 != cand) begin
        cand  <= sync2;
        cnt   <= '0;
        state <= WAIT;
      end else begin
        unique case (state)
          WAIT:    if (cnt == CNT_LAST) state <= DECODE;
                   else                 cnt   <= cnt + 8'd1;
          DECODE:  state <= HOLD;
          default: state <= HOLD;
        endcase
      end
    end
  end

endmodule
